// File: rtl/mtimer_pkg.sv
// ============================================================================
// Module      : mtimer_pkg
// Description : Shared register map, CTRL layout and byte-strobe helper for
//               the APB machine timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mtimer_pkg;

  // Word indices as decoded from paddr[4:2]
  localparam logic [2:0] MTIME_LO_OFF    = 3'd0;
  localparam logic [2:0] MTIME_HI_OFF    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO_OFF = 3'd2;
  localparam logic [2:0] MTIMECMP_HI_OFF = 3'd3;
  localparam logic [2:0] CTRL_OFF        = 3'd4;
  localparam logic [2:0] STATUS_OFF      = 3'd5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_W   = 8;

  typedef struct packed {
    logic [CTRL_PRESC_W-1:0] presc;
    logic                    en;
  } ctrl_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] i_old,
                                             input logic [31:0] i_wdata,
                                             input logic [3:0]  i_strb);
    logic [31:0] v;
    v = i_old;
    for (int b = 0; b < 4; b++) begin
      if (i_strb[b]) v[8*b +: 8] = i_wdata[8*b +: 8];
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mtimer_counter.sv
// ============================================================================
// Module      : mtimer_counter
// Description : 64-bit mtime counter split into two 32-bit words, with tick
//               input, LO->HI carry and per-word write override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtimer_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata_lo,
  input  logic [31:0] i_wdata_hi,
  output logic [63:0] o_mtime
);

  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        w_carry;

  // A write to LO replaces the value that would have wrapped, so no carry.
  assign w_carry = i_tick & (&r_lo) & ~i_wr_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo <= 32'd0;
      r_hi <= 32'd0;
    end else begin
      if (i_wr_lo)     r_lo <= i_wdata_lo;
      else if (i_tick) r_lo <= r_lo + 32'd1;

      if (i_wr_hi)      r_hi <= i_wdata_hi;
      else if (w_carry) r_hi <= r_hi + 32'd1;
    end
  end

  assign o_mtime = {r_hi, r_lo};

endmodule

`default_nettype wire

// File: rtl/apb_mtimer.sv
// ============================================================================
// Module      : apb_mtimer
// Description : APB machine timer (mtime/mtimecmp/CTRL/STATUS) driving a
//               registered level timer interrupt. Optional prescaler is
//               built when MTIMER_PRESCALER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_mtimer
  import mtimer_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  input  logic [2:0]        pprot,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              timer_interrupt
);

  ctrl_t       r_ctrl;
  logic [63:0] r_cmp;
  logic        r_irq;

  logic [63:0] w_mtime;
  logic        w_tick;
  logic        w_pending;
  logic [2:0]  w_off;
  logic        w_access;
  logic        w_valid;
  logic        w_wr;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_ctrl;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Only paddr[4:2] selects a register; protection bits carry no meaning here.
  assign w_unused = ^{pprot, paddr[ADDR_W-1:5], paddr[1:0]};

  assign w_off    = paddr[4:2];
  assign w_access = psel & penable & ~rst;
  assign w_valid  = (w_off <= STATUS_OFF);
  assign w_wr     = w_access & pwrite;

  assign w_wr_mtime_lo = w_wr & (w_off == MTIME_LO_OFF);
  assign w_wr_mtime_hi = w_wr & (w_off == MTIME_HI_OFF);
  assign w_wr_cmp_lo   = w_wr & (w_off == MTIMECMP_LO_OFF);
  assign w_wr_cmp_hi   = w_wr & (w_off == MTIMECMP_HI_OFF);
  assign w_wr_ctrl     = w_wr & (w_off == CTRL_OFF);

  assign pready  = 1'b1;
  assign pslverr = w_access & (~w_valid | (pwrite & (w_off == STATUS_OFF)));

`ifdef MTIMER_PRESCALER_EN
  logic [CTRL_PRESC_W-1:0] r_presc_cnt;
  logic                    w_presc_hit;

  assign w_presc_hit = (r_presc_cnt == r_ctrl.presc);
  assign w_tick      = r_ctrl.en & w_presc_hit;

  always_ff @(posedge clk) begin
    if (rst || !r_ctrl.en || w_wr_ctrl || w_presc_hit) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end
`else
  assign w_tick = r_ctrl.en;
`endif

  mtimer_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (w_tick),
    .i_wr_lo    (w_wr_mtime_lo),
    .i_wr_hi    (w_wr_mtime_hi),
    .i_wdata_lo (strb_merge(w_mtime[31:0],  pwdata, pstrb)),
    .i_wdata_hi (strb_merge(w_mtime[63:32], pwdata, pstrb)),
    .o_mtime    (w_mtime)
  );

  assign w_pending = (w_mtime >= r_cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_cmp  <= CMP_RESET;
      r_irq  <= 1'b0;
    end else begin
      r_irq <= w_pending;
      if (w_wr_cmp_lo) r_cmp[31:0]  <= strb_merge(r_cmp[31:0],  pwdata, pstrb);
      if (w_wr_cmp_hi) r_cmp[63:32] <= strb_merge(r_cmp[63:32], pwdata, pstrb);
      if (w_wr_ctrl) begin
        if (pstrb[0]) r_ctrl.en <= pwdata[CTRL_EN_BIT];
`ifdef MTIMER_PRESCALER_EN
        if (pstrb[1]) r_ctrl.presc <= pwdata[CTRL_PRESC_LSB +: CTRL_PRESC_W];
`endif
      end
    end
  end

  assign timer_interrupt = r_irq;

  always_comb begin
    w_rdata = '0;
    if (w_access && !pwrite) begin
      case (w_off)
        MTIME_LO_OFF:    w_rdata = w_mtime[31:0];
        MTIME_HI_OFF:    w_rdata = w_mtime[63:32];
        MTIMECMP_LO_OFF: w_rdata = r_cmp[31:0];
        MTIMECMP_HI_OFF: w_rdata = r_cmp[63:32];
        CTRL_OFF: begin
          w_rdata[CTRL_EN_BIT]                     = r_ctrl.en;
          w_rdata[CTRL_PRESC_LSB +: CTRL_PRESC_W]  = r_ctrl.presc;
        end
        STATUS_OFF:      w_rdata[0] = w_pending;
        default:         w_rdata = '0;
      endcase
    end
  end

  assign prdata = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_mtimer.sv
// ============================================================================
// Module      : tb_apb_mtimer
// Description : Scoreboard bench for apb_mtimer with a 64-bit arithmetic
//               reference model and randomized APB traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_mtimer;

  localparam int          ADDR_W    = 12;
  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk;
  logic              rst;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              timer_interrupt;

  apb_mtimer #(.ADDR_W(ADDR_W), .CMP_RESET(CMP_RESET)) dut (
    .clk             (clk),
    .rst             (rst),
    .psel            (psel),
    .penable         (penable),
    .pwrite          (pwrite),
    .paddr           (paddr),
    .pwdata          (pwdata),
    .pstrb           (pstrb),
    .pprot           (pprot),
    .prdata          (prdata),
    .pready          (pready),
    .pslverr         (pslverr),
    .timer_interrupt (timer_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [2:0]  off;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [7:0]  m_presc;
  logic [7:0]  m_cnt;
  logic        m_irq;
  logic        m_wr;
  logic [2:0]  m_off;
  logic        m_tick;

  assign m_wr  = psel & penable & pwrite & ~rst;
  assign m_off = paddr[4:2];
`ifdef MTIMER_PRESCALER_EN
  assign m_tick = m_en && (m_cnt == m_presc);
`else
  assign m_tick = m_en;
`endif

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] model_next_mtime();
    logic [63:0] inc;
    inc = m_tick ? m_mtime + 64'd1 : m_mtime;
    if (m_wr && m_off == 3'd0) return {m_mtime[63:32], mrg(m_mtime[31:0], pwdata, pstrb)};
    if (m_wr && m_off == 3'd1) return {mrg(m_mtime[63:32], pwdata, pstrb), inc[31:0]};
    return inc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mtime <= 64'd0;
      m_cmp   <= CMP_RESET;
      m_en    <= 1'b0;
      m_presc <= 8'd0;
      m_cnt   <= 8'd0;
      m_irq   <= 1'b0;
    end else begin
      m_irq   <= (m_mtime >= m_cmp);
      m_mtime <= model_next_mtime();
      if (m_wr && m_off == 3'd2) m_cmp <= {m_cmp[63:32], mrg(m_cmp[31:0], pwdata, pstrb)};
      if (m_wr && m_off == 3'd3) m_cmp <= {mrg(m_cmp[63:32], pwdata, pstrb), m_cmp[31:0]};
      if (m_wr && m_off == 3'd4) begin
        if (pstrb[0]) m_en <= pwdata[0];
`ifdef MTIMER_PRESCALER_EN
        if (pstrb[1]) m_presc <= pwdata[15:8];
`endif
      end
      if (!m_en || (m_wr && m_off == 3'd4) || m_cnt == m_presc) m_cnt <= 8'd0;
      else m_cnt <= m_cnt + 8'd1;
    end
  end

  function automatic exp_t model_resp(input logic wr, input logic [2:0] off);
    exp_t e;
    e.off  = off;
    e.data = 32'd0;
    e.err  = (off > 3'd5) || (wr && off == 3'd5);
    if (!wr) begin
      case (off)
        3'd0: e.data = m_mtime[31:0];
        3'd1: e.data = m_mtime[63:32];
        3'd2: e.data = m_cmp[31:0];
        3'd3: e.data = m_cmp[63:32];
        3'd4: e.data = {16'd0, m_presc, 7'd0, m_en};
        3'd5: e.data = {31'd0, (m_mtime >= m_cmp)};
        default: e.data = 32'd0;
      endcase
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (armed) begin
      if (psel && penable) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL apb_unexpected_access paddr=%h prdata=%h required=no access", paddr, prdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (prdata !== e.data || pslverr !== e.err || pready !== 1'b1) begin
            n_fail++;
            $display("FAIL apb_resp off=%0d actual prdata=%h pslverr=%b pready=%b required prdata=%h pslverr=%b pready=1",
                     e.off, prdata, pslverr, pready, e.data, e.err);
          end
        end
      end
      n_tests++;
      if (timer_interrupt !== m_irq) begin
        n_fail++;
        $display("FAIL irq_level t=%0t actual=%b required=%b", $time, timer_interrupt, m_irq);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit use_exp, input logic [31:0] exp_data,
                      input logic exp_err);
    exp_t e;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    pprot   = 3'($urandom);
    @(posedge clk); #1;
    penable = 1'b1;
    if (use_exp) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.off  = addr[4:2];
    end else begin
      e = model_resp(wr, addr[4:2]);
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    xfer(1'b1, a, d, s, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    xfer(1'b0, a, 32'd0, 4'h0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic err = 1'b0);
    xfer(1'b0, a, 32'd0, 4'h0, 1'b1, d, err);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int rise_k;

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    @(posedge clk); #1;
    armed = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("irq_after_reset", {31'd0, timer_interrupt}, 32'd0);
    rd_exp(12'h000, 32'h0);
    rd_exp(12'h004, 32'h0);
    rd_exp(12'h008, 32'hFFFF_FFFF);
    rd_exp(12'h00C, 32'hFFFF_FFFF);
    rd_exp(12'h010, 32'h0);
    rd_exp(12'h014, 32'h0);
    rd_exp(12'h018, 32'h0, 1'b1);
    rd_exp(12'h01C, 32'h0, 1'b1);

    // compare/interrupt timing
    wr(12'h008, 32'd10);
    wr(12'h00C, 32'd0);
    wr(12'h010, 32'd1);
    rise_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (timer_interrupt === 1'b1) begin
        rise_k = k;
        break;
      end
    end
    check("irq_rise_cycles", rise_k, 32'd11);
    wr(12'h008, 32'h0000_FFFF);
    check("irq_still_high_at_write_edge", {31'd0, timer_interrupt}, 32'd1);
    @(posedge clk); #1;
    check("irq_fall_after_cmp_raise", {31'd0, timer_interrupt}, 32'd0);

    // carry from LO to HI
    wr(12'h010, 32'd0);
    wr(12'h000, 32'hFFFF_FFFE);
    wr(12'h004, 32'd5);
    wr(12'h010, 32'd1);
    wr(12'h010, 32'd0);
    rd_exp(12'h000, 32'd0);
    rd_exp(12'h004, 32'd6);

    // LO write in the carry cycle suppresses the carry
    wr(12'h000, 32'hFFFF_FFFE);
    wr(12'h004, 32'd5);
    wr(12'h010, 32'd1);
    wr(12'h000, 32'h0000_0123);
    wr(12'h010, 32'd0);
    rd_exp(12'h004, 32'd5);
    rd_exp(12'h000, 32'h0000_0125);

    // error responses
    rd_exp(12'h018, 32'd0, 1'b1);
    rd_exp(12'h014, 32'd1);
    wr(12'h014, 32'd1);
    wr(12'h014, 32'd0);
    rd_exp(12'h014, 32'd1);

    // byte strobes
    do_reset();
    wr(12'h008, 32'h0000_00AA, 4'b0001);
    rd_exp(12'h008, 32'hFFFF_FFAA);
    wr(12'h00C, 32'h1234_5678, 4'b1010);
    rd_exp(12'h00C, 32'h12FF_56FF);

`ifdef MTIMER_PRESCALER_EN
    do_reset();
    wr(12'h010, 32'h0000_0301);
    repeat (22) @(posedge clk);
    #1;
    rd_exp(12'h000, 32'd5);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    @(posedge clk); #1;
    penable = 1'b1;
    rst = 1'b1;
    exp_q.push_back('{data: 32'd0, err: 1'b0, off: 3'd0});
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_exp(12'h000, 32'd0);
    check("irq_low_after_mid_reset", {31'd0, timer_interrupt}, 32'd0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [2:0]  off;
      logic [31:0] d;
      logic [3:0]  s;
      logic [ADDR_W-1:0] a;
      op  = $urandom_range(0, 9);
      off = 3'($urandom_range(0, 7));
      a   = ADDR_W'($urandom);
      a[4:2] = off;
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      if (off == 3'd1 || off == 3'd3) d = $urandom_range(0, 1);
      else if ((off == 3'd0 || off == 3'd2) && $urandom_range(0, 1) == 1) d = $urandom_range(0, 60);
      else if (off == 3'd4) d = {16'd0, 8'($urandom_range(0, 3)), 7'd0, 1'($urandom_range(0, 3) != 0)};
      if (op <= 3)      rd(a);
      else if (op <= 7) wr(a, d, s);
      else if (op == 8) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end else rd(12'h014);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
